tj_trig_seq: RTL and testbench

Sequence-detecting trigger generator for the AES-T2000 benchmark. It watches the plaintext words presented to the AES core and asserts `Tj_Trig` only after a fixed, ordered sequence of four plaintext values has been seen. `Tj_Trig` is the trigger input of the downstream key-leak stage `TSC`, which loads its key on the rising edge of `Tj_Trig`. This block is therefore its direct upstream feeder.

---
 rtl/tj_pkg.sv | 15 +
 rtl/pt_match4.sv | 12 +
 rtl/tj_trig_seq.sv | 53 +++++
 tb/tb_tj_trig_seq.sv | 125 ++++++++++++
 4 files changed

// File: rtl/tj_pkg.sv
// tj_pkg: shared FSM encoding, default trigger patterns and counter limit for the sequence trigger.
package tj_pkg;
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S1   = 3'd1,
      S2   = 3'd2,
      S3   = 3'd3,
      FIRE = 3'd4
   } tj_state_e;
   localparam logic [127:0] TJ_PAT0 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] TJ_PAT1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] TJ_PAT2 = 128'h0;
   localparam logic [127:0] TJ_PAT3 = 128'hffffffffffffffffffffffffffffffff;
   localparam logic [7:0]   FIRE_CNT_MAX = 8'hFF;
endpackage

// File: rtl/pt_match4.sv
// pt_match4: combinational full-width compare of one plaintext word against the four trigger patterns.
module pt_match4 import tj_pkg::*; #(
   parameter logic [127:0] PAT0 = TJ_PAT0,
   parameter logic [127:0] PAT1 = TJ_PAT1,
   parameter logic [127:0] PAT2 = TJ_PAT2,
   parameter logic [127:0] PAT3 = TJ_PAT3
) (
   input  logic [127:0] state,
   output logic [3:0]   m
);
   assign m = {state == PAT3, state == PAT2, state == PAT1, state == PAT0};
endmodule

// File: rtl/tj_trig_seq.sv
// tj_trig_seq: raises Tj_Trig for HOLD_CYCLES cycles after the ordered plaintexts PAT0..PAT3 are observed.
module tj_trig_seq import tj_pkg::*; #(
   parameter logic [127:0] PAT0 = TJ_PAT0,
   parameter logic [127:0] PAT1 = TJ_PAT1,
   parameter logic [127:0] PAT2 = TJ_PAT2,
   parameter logic [127:0] PAT3 = TJ_PAT3,
   parameter int           HOLD_CYCLES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] state,
   input  logic         pt_valid,
   output logic         Tj_Trig,
   output logic [2:0]   arm_state,
   output logic [7:0]   fire_cnt
);
   localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);
   tj_state_e  st_q, st_d;
   logic [7:0] hold_q;
   logic [3:0] m;
   logic       entry;
   pt_match4 #(.PAT0(PAT0), .PAT1(PAT1), .PAT2(PAT2), .PAT3(PAT3)) u_match (
      .state (state),
      .m     (m)
   );
   // forward progress is tested before the PAT0 restart so equal adjacent patterns advance
   always_comb begin
      st_d = st_q;
      case (st_q)
         IDLE:    st_d = (pt_valid && m[0]) ? S1 : IDLE;
         S1:      st_d = !pt_valid ? S1 : m[1] ? S2 : m[0] ? S1 : IDLE;
         S2:      st_d = !pt_valid ? S2 : m[2] ? S3 : m[0] ? S1 : IDLE;
         S3:      st_d = !pt_valid ? S3 : m[3] ? FIRE : m[0] ? S1 : IDLE;
         FIRE:    st_d = (hold_q == 8'd0) ? IDLE : FIRE;
         default: st_d = IDLE;
      endcase
   end
   assign entry = (st_d == FIRE) && (st_q != FIRE);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q     <= IDLE;
         hold_q   <= 8'd0;
         fire_cnt <= 8'd0;
      end else begin
         st_q   <= st_d;
         hold_q <= entry ? HOLD_M1 : (st_q == FIRE && hold_q != 8'd0) ? hold_q - 8'd1 : hold_q;
         if (entry && fire_cnt != FIRE_CNT_MAX)
            fire_cnt <= fire_cnt + 8'd1;
      end
   end
   assign Tj_Trig   = (st_q == FIRE);
   assign arm_state = st_q;
endmodule

// File: tb/tb_tj_trig_seq.sv
// tb_tj_trig_seq: directed scoreboard bench for the sequence trigger with per-cycle expected outputs.
module tb_tj_trig_seq;
   localparam logic [127:0] P0 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] P2 = 128'h0;
   localparam logic [127:0] P3 = 128'hffffffffffffffffffffffffffffffff;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         pt_valid = 1'b0;
   logic [127:0] state = '0;
   logic         Tj_Trig;
   logic [2:0]   arm_state;
   logic [7:0]   fire_cnt;
   typedef struct {
      int         tag;
      logic       trig;
      logic [2:0] arm;
      logic [7:0] fc;
      string      name;
   } exp_t;
   exp_t q[$];
   exp_t aq[$];
   int cyc = 0;
   int total = 0;
   int bad = 0;
   tj_trig_seq dut (
      .clk       (clk),
      .rst       (rst),
      .state     (state),
      .pt_valid  (pt_valid),
      .Tj_Trig   (Tj_Trig),
      .arm_state (arm_state),
      .fire_cnt  (fire_cnt)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input exp_t e);
      total++;
      if (Tj_Trig !== e.trig || arm_state !== e.arm || fire_cnt !== e.fc) begin
         bad++;
         $display("FAIL %s @cyc %0d: got trig=%b arm=%0d fc=%0d, want trig=%b arm=%0d fc=%0d",
                  e.name, cyc, Tj_Trig, arm_state, fire_cnt, e.trig, e.arm, e.fc);
      end
   endtask
   // monitor: expectations are tagged with the cycle whose outputs they describe
   always @(negedge clk)
      while (q.size() > 0 && q[0].tag <= cyc) check(q.pop_front());
   always @(negedge rst) begin
      #1;
      while (aq.size() > 0) check(aq.pop_front());
   end
   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   task automatic step(input logic v, input logic [127:0] d, input logic t,
                       input logic [2:0] a, input logic [7:0] f, input string n);
      @(negedge clk);
      pt_valid = v;
      state = d;
      q.push_back('{tag: cyc + 1, trig: t, arm: a, fc: f, name: n});
   endtask
   task automatic idle2(input logic [2:0] a, input logic [7:0] f, input string n);
      repeat (2) step(1'b0, rnd128(), 1'b0, a, f, n);
   endtask
   task automatic run_seq(input logic [7:0] f0, input logic [7:0] f1, input logic fill, input string n);
      step(1'b1, P0, 1'b0, 3'd1, f0, n);
      step(1'b1, P1, 1'b0, 3'd2, f0, n);
      step(1'b1, P2, 1'b0, 3'd3, f0, n);
      step(1'b1, P3, 1'b1, 3'd4, f1, n);
      repeat (3) step(fill, P0, 1'b1, 3'd4, f1, n);
      step(fill, P0, 1'b0, 3'd0, f1, n);
   endtask
   initial begin
      repeat (3) step(1'($urandom_range(1)), rnd128(), 1'b0, 3'd0, 8'd0, "reset");
      @(negedge clk);
      rst = 1'b1;
      pt_valid = 1'b0;
      step(1'b0, P0, 1'b0, 3'd0, 8'd0, "post_reset");
      run_seq(8'd0, 8'd1, 1'b0, "clean");
      step(1'b1, P0, 1'b0, 3'd1, 8'd1, "gap_w1");
      idle2(3'd1, 8'd1, "gap_i1");
      step(1'b1, P1, 1'b0, 3'd2, 8'd1, "gap_w2");
      idle2(3'd2, 8'd1, "gap_i2");
      step(1'b1, P0, 1'b0, 3'd1, 8'd1, "gap_restart");
      idle2(3'd1, 8'd1, "gap_i3");
      step(1'b1, P1, 1'b0, 3'd2, 8'd1, "gap_w4");
      idle2(3'd2, 8'd1, "gap_i4");
      step(1'b1, P2, 1'b0, 3'd3, 8'd1, "gap_w5");
      idle2(3'd3, 8'd1, "gap_i5");
      step(1'b1, P3, 1'b1, 3'd4, 8'd2, "gap_fire");
      repeat (3) step(1'b1, P0, 1'b1, 3'd4, 8'd2, "fire_ignore");
      step(1'b1, P0, 1'b0, 3'd0, 8'd2, "fire_exit");
      step(1'b1, P1, 1'b0, 3'd0, 8'd2, "idle_p1");
      step(1'b1, P0, 1'b0, 3'd1, 8'd2, "brk_w1");
      step(1'b1, P1, 1'b0, 3'd2, 8'd2, "brk_w2");
      step(1'b1, 128'h5, 1'b0, 3'd0, 8'd2, "brk_w3");
      step(1'b1, P3, 1'b0, 3'd0, 8'd2, "brk_w4");
      step(1'b1, P0, 1'b0, 3'd1, 8'd2, "mid_w1");
      step(1'b1, P1, 1'b0, 3'd2, 8'd2, "mid_w2");
      step(1'b1, P2, 1'b0, 3'd3, 8'd2, "mid_w3");
      step(1'b1, P3, 1'b1, 3'd4, 8'd3, "mid_fire1");
      step(1'b0, P0, 1'b1, 3'd4, 8'd3, "mid_fire2");
      @(negedge clk);
      #2;
      aq.push_back('{tag: 0, trig: 1'b0, arm: 3'd0, fc: 8'd0, name: "async_reset"});
      rst = 1'b0;
      repeat (2) step(1'($urandom_range(1)), rnd128(), 1'b0, 3'd0, 8'd0, "in_reset");
      @(negedge clk);
      rst = 1'b1;
      pt_valid = 1'b0;
      run_seq(8'd0, 8'd1, 1'b0, "rerun");
      for (int i = 0; i < 256; i++)
         run_seq((i + 1 > 255) ? 8'd255 : 8'(i + 1), (i + 2 > 255) ? 8'd255 : 8'(i + 2), 1'b1, "sat");
      step(1'b0, P0, 1'b0, 3'd0, 8'd255, "sat_end");
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (q.size() + aq.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", q.size() + aq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
